riscv_core_dcache_data_array: RTL and testbench

//  N-way set-associative D-cache data array; successor to the direct-mapped data memory.

---
 rtl/riscv_core_dcache_data_array.sv | 233 +++++++++++++++++++++++
 tb/tb_riscv_core_dcache_data_array.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/riscv_core_dcache_data_array.sv
// Set-associative D-cache data array: core byte/half/word/dword access with registered read,
// plus a multi-beat line-fill writer and a victim write-back reader toward the AXI adapter.
module riscv_core_dcache_data_array #(
    parameter int unsigned WAYS            = 2,
    parameter int unsigned INDEX_WIDTH     = 7,
    parameter int unsigned BLOCK_OFFSET    = 2,
    parameter int unsigned CORE_DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH      = 64,
    parameter int unsigned AXI_DATA_WIDTH  = 128,
    localparam int unsigned WW             = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [ADDR_WIDTH-1:0]      i_addr,
    input  logic [WW-1:0]              i_way_sel,
    input  logic                       i_rd_en,
    input  logic                       i_wr_en,
    input  logic [1:0]                 i_size,
    input  logic [CORE_DATA_WIDTH-1:0] i_wdata,
    input  logic                       i_amo_wr,
    input  logic [CORE_DATA_WIDTH-1:0] i_amo_alu_result,
    output logic [CORE_DATA_WIDTH-1:0] o_rdata,
    output logic                       o_rvalid,
    output logic                       o_misaligned,
    output logic                       o_busy,
    input  logic                       i_fill_start,
    input  logic                       i_fill_valid,
    input  logic [AXI_DATA_WIDTH-1:0]  i_fill_data,
    output logic                       o_fill_ready,
    output logic                       o_fill_done,
    input  logic                       i_evict_start,
    output logic                       o_evict_valid,
    output logic [AXI_DATA_WIDTH-1:0]  o_evict_data,
    output logic                       o_evict_last,
    input  logic                       i_evict_ready
);

    localparam int unsigned WORDS   = 1 << BLOCK_OFFSET;
    localparam int unsigned WPB     = AXI_DATA_WIDTH / CORE_DATA_WIDTH;
    localparam int unsigned BEATS   = WORDS / WPB;
    localparam int unsigned CW      = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned EW      = WW + INDEX_WIDTH + BLOCK_OFFSET;
    localparam int unsigned ENTRIES = 1 << EW;
    localparam int unsigned TOPB    = BLOCK_OFFSET + 3 + INDEX_WIDTH;

    typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_EVICT} state_e;

    state_e                       state_q, state_d;
    logic [CW-1:0]                cnt_q, cnt_d;
    logic [INDEX_WIDTH-1:0]       idx_q, idx_d;
    logic [WW-1:0]                way_q, way_d;
    logic                         fill_done_q, fill_done_d;
    logic                         evict_valid_q, evict_valid_d;
    logic [AXI_DATA_WIDTH-1:0]    evict_data_q, evict_data_d;
    logic [CORE_DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                         rvalid_q, rvalid_d;

    logic [CORE_DATA_WIDTH-1:0]   mem_q [ENTRIES];

    logic [2:0]                   off;
    logic [INDEX_WIDTH-1:0]       req_set;
    logic [EW-1:0]                core_e;
    logic                         is_idle, req_bad, core_we, core_re, fill_we;
    logic [7:0]                   size_mask, byte_mask;
    logic [CORE_DATA_WIDTH-1:0]   st_src, st_data, rd_shift, rd_ext;
    logic [CW-1:0]                ev_sel;
    logic [AXI_DATA_WIDTH-1:0]    ev_beat;
    logic                         unused_addr_bits;

    function automatic logic [EW-1:0] line_entry(input logic [WW-1:0] w,
                                                 input logic [INDEX_WIDTH-1:0] s,
                                                 input logic [CW-1:0] b,
                                                 input int unsigned k);
        return {w, s, BLOCK_OFFSET'(b * WPB + k)};
    endfunction

    assign unused_addr_bits = ^i_addr[ADDR_WIDTH-1:TOPB];

    assign off     = i_addr[2:0];
    assign req_set = i_addr[BLOCK_OFFSET+3 +: INDEX_WIDTH];
    assign core_e  = {i_way_sel, req_set, i_addr[3 +: BLOCK_OFFSET]};
    assign is_idle = (state_q == ST_IDLE);

    // AMO writes narrower than a word are treated like a misaligned access
    assign req_bad = ((i_size == 2'b01) && off[0])
                   || ((i_size == 2'b10) && (off[1:0] != 2'b00))
                   || ((i_size == 2'b11) && (off != 3'b000))
                   || (i_wr_en && i_amo_wr && !i_size[1]);
    assign core_we = is_idle && !req_bad && i_wr_en;
    assign core_re = is_idle && !req_bad && i_rd_en;
    assign fill_we = (state_q == ST_FILL) && i_fill_valid;

    always_comb begin
        size_mask = 8'h01;
        case (i_size)
            2'b00: size_mask = 8'h01;
            2'b01: size_mask = 8'h03;
            2'b10: size_mask = 8'h0F;
            2'b11: size_mask = 8'hFF;
            default: size_mask = 8'h01;
        endcase
        byte_mask = size_mask << off;
        st_src    = i_amo_wr ? i_amo_alu_result : i_wdata;
        st_data   = st_src << {off, 3'b000};
        rd_shift  = mem_q[core_e] >> {off, 3'b000};
        rd_ext    = rd_shift;
        case (i_size)
            2'b00: rd_ext = CORE_DATA_WIDTH'(rd_shift[7:0]);
            2'b01: rd_ext = CORE_DATA_WIDTH'(rd_shift[15:0]);
            2'b10: rd_ext = CORE_DATA_WIDTH'(rd_shift[31:0]);
            default: rd_ext = rd_shift;
        endcase
    end

    // First EVICT cycle loads beat 0; afterwards the register is refilled with the following beat
    assign ev_sel = evict_valid_q ? cnt_q + 1'b1 : '0;

    always_comb begin
        ev_beat = '0;
        for (int unsigned k = 0; k < WPB; k++) begin
            ev_beat[k*CORE_DATA_WIDTH +: CORE_DATA_WIDTH] = mem_q[line_entry(way_q, idx_q, ev_sel, k)];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            idx_q         <= '0;
            way_q         <= '0;
            fill_done_q   <= 1'b0;
            evict_valid_q <= 1'b0;
            evict_data_q  <= '0;
            rdata_q       <= '0;
            rvalid_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            way_q         <= way_d;
            fill_done_q   <= fill_done_d;
            evict_valid_q <= evict_valid_d;
            evict_data_q  <= evict_data_d;
            rdata_q       <= rdata_d;
            rvalid_q      <= rvalid_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        way_d         = way_q;
        fill_done_d   = 1'b0;
        evict_valid_d = evict_valid_q;
        evict_data_d  = evict_data_q;
        rdata_d       = rdata_q;
        rvalid_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (core_re) begin
                    rvalid_d = 1'b1;
                    rdata_d  = rd_ext;
                end
                if (i_evict_start || i_fill_start) begin
                    state_d = i_evict_start ? ST_EVICT : ST_FILL;
                    idx_d   = req_set;
                    way_d   = i_way_sel;
                    cnt_d   = '0;
                end
            end
            ST_FILL: begin
                if (i_fill_valid) begin
                    if (cnt_q == CW'(BEATS - 1)) begin
                        state_d     = ST_IDLE;
                        cnt_d       = '0;
                        fill_done_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_EVICT: begin
                if (!evict_valid_q) begin
                    evict_valid_d = 1'b1;
                    evict_data_d  = ev_beat;
                end else if (i_evict_ready) begin
                    if (cnt_q == CW'(BEATS - 1)) begin
                        state_d       = ST_IDLE;
                        evict_valid_d = 1'b0;
                        cnt_d         = '0;
                    end else begin
                        cnt_d        = cnt_q + 1'b1;
                        evict_data_d = ev_beat;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        o_busy        = !is_idle;
        o_fill_ready  = (state_q == ST_FILL);
        o_fill_done   = fill_done_q;
        o_evict_valid = evict_valid_q;
        o_evict_data  = evict_data_q;
        o_evict_last  = evict_valid_q && (cnt_q == CW'(BEATS - 1));
        o_misaligned  = is_idle && (i_rd_en || i_wr_en) && req_bad;
        o_rdata       = rdata_q;
        o_rvalid      = rvalid_q;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned e = 0; e < ENTRIES; e++) begin
                mem_q[EW'(e)] <= '0;
            end
        end else begin
            if (core_we) begin
                for (int unsigned b = 0; b < 8; b++) begin
                    if (byte_mask[3'(b)]) mem_q[core_e][b*8 +: 8] <= st_data[b*8 +: 8];
                end
            end
            if (fill_we) begin
                for (int unsigned k = 0; k < WPB; k++) begin
                    mem_q[line_entry(way_q, idx_q, cnt_q, k)] <= i_fill_data[k*CORE_DATA_WIDTH +: CORE_DATA_WIDTH];
                end
            end
        end
    end

endmodule

// File: tb/tb_riscv_core_dcache_data_array.sv
// Directed bench for the D-cache data array: core access, alignment, fill, evict and reset abort.
module tb_riscv_core_dcache_data_array;

    logic         i_clk;
    logic         i_rst_n;
    logic [63:0]  i_addr;
    logic [0:0]   i_way_sel;
    logic         i_rd_en, i_wr_en, i_amo_wr;
    logic [1:0]   i_size;
    logic [63:0]  i_wdata, i_amo_alu_result;
    logic [63:0]  o_rdata;
    logic         o_rvalid, o_misaligned, o_busy;
    logic         i_fill_start, i_fill_valid;
    logic [127:0] i_fill_data;
    logic         o_fill_ready, o_fill_done;
    logic         i_evict_start;
    logic         o_evict_valid;
    logic [127:0] o_evict_data;
    logic         o_evict_last;
    logic         i_evict_ready;

    int total = 0;
    int bad   = 0;

    localparam logic [127:0] BEAT0 = {64'h1111_1111_1111_1102, 64'h1111_1111_1111_1101};
    localparam logic [127:0] BEAT1 = {64'h2222_2222_2222_2204, 64'h2222_2222_2222_2203};

    riscv_core_dcache_data_array #(
        .WAYS(2), .INDEX_WIDTH(7), .BLOCK_OFFSET(2),
        .CORE_DATA_WIDTH(64), .ADDR_WIDTH(64), .AXI_DATA_WIDTH(128)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_addr(i_addr), .i_way_sel(i_way_sel),
        .i_rd_en(i_rd_en), .i_wr_en(i_wr_en), .i_size(i_size), .i_wdata(i_wdata),
        .i_amo_wr(i_amo_wr), .i_amo_alu_result(i_amo_alu_result),
        .o_rdata(o_rdata), .o_rvalid(o_rvalid), .o_misaligned(o_misaligned), .o_busy(o_busy),
        .i_fill_start(i_fill_start), .i_fill_valid(i_fill_valid), .i_fill_data(i_fill_data),
        .o_fill_ready(o_fill_ready), .o_fill_done(o_fill_done),
        .i_evict_start(i_evict_start), .o_evict_valid(o_evict_valid), .o_evict_data(o_evict_data),
        .o_evict_last(o_evict_last), .i_evict_ready(i_evict_ready)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge i_clk);
        #1;
    endtask

    // AMO requests carry the value on i_amo_alu_result and its complement on i_wdata
    task automatic req(input logic rd, input logic wr, input logic amo, input logic [1:0] sz,
                       input logic [63:0] a, input logic w, input logic [63:0] d);
        i_rd_en = rd; i_wr_en = wr; i_amo_wr = amo; i_size = sz; i_addr = a; i_way_sel = w;
        i_wdata = amo ? ~d : d;
        i_amo_alu_result = amo ? d : ~d;
        #1;
    endtask

    task automatic req_off();
        i_rd_en = 1'b0; i_wr_en = 1'b0; i_amo_wr = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] sz, input logic [63:0] a,
                          input logic w, input logic [63:0] exp);
        req(1'b1, 1'b0, 1'b0, sz, a, w, 64'h0);
        cyc();
        req_off();
        chk({tag, "_rvalid"}, 128'(o_rvalid), 128'(1'b1));
        chk(tag, 128'(o_rdata), 128'(exp));
    endtask

    initial begin
        i_rst_n = 1'b0; i_addr = '0; i_way_sel = '0; i_rd_en = 1'b0; i_wr_en = 1'b0;
        i_amo_wr = 1'b0; i_size = 2'b00; i_wdata = '0; i_amo_alu_result = '0;
        i_fill_start = 1'b0; i_fill_valid = 1'b0; i_fill_data = '0;
        i_evict_start = 1'b0; i_evict_ready = 1'b0;
        cyc(); cyc();
        chk("rst_rdata", 128'(o_rdata), 128'h0);
        chk("rst_rvalid", 128'(o_rvalid), 128'h0);
        chk("rst_busy", 128'(o_busy), 128'h0);
        chk("rst_fill_ready", 128'(o_fill_ready), 128'h0);
        chk("rst_evict_valid", 128'(o_evict_valid), 128'h0);
        chk("rst_fill_done", 128'(o_fill_done), 128'h0);
        i_rst_n = 1'b1;
        cyc();

        rd_chk("rd_s5w1_init", 2'b11, 64'hA0, 1'b1, 64'h0);

        req(1'b0, 1'b1, 1'b0, 2'b10, 64'hA4, 1'b0, 64'hDEAD_BEEF);
        chk("w_store_misal", 128'(o_misaligned), 128'h0);
        cyc(); req_off();
        chk("w_store_no_rvalid", 128'(o_rvalid), 128'h0);
        rd_chk("rd_d_a0_w0", 2'b11, 64'hA0, 1'b0, 64'hDEAD_BEEF_0000_0000);
        rd_chk("rd_d_a0_w1", 2'b11, 64'hA0, 1'b1, 64'h0);
        rd_chk("rd_b_a5", 2'b00, 64'hA5, 1'b0, 64'hBE);
        rd_chk("rd_h_a6", 2'b01, 64'hA6, 1'b0, 64'hDEAD);
        rd_chk("rd_w_a4", 2'b10, 64'hA4, 1'b0, 64'hDEAD_BEEF);

        req(1'b0, 1'b1, 1'b0, 2'b01, 64'hA1, 1'b0, 64'h1234);
        chk("h_misal_flag", 128'(o_misaligned), 128'h1);
        cyc(); req_off();
        rd_chk("rd_after_h_misal", 2'b11, 64'hA0, 1'b0, 64'hDEAD_BEEF_0000_0000);
        req(1'b0, 1'b1, 1'b1, 2'b00, 64'hA0, 1'b0, 64'hFF);
        chk("amo_b_flag", 128'(o_misaligned), 128'h1);
        cyc(); req_off();
        rd_chk("rd_after_amo_b", 2'b11, 64'hA0, 1'b0, 64'hDEAD_BEEF_0000_0000);
        req(1'b1, 1'b0, 1'b0, 2'b10, 64'hA2, 1'b0, 64'h0);
        chk("w_rd_misal_flag", 128'(o_misaligned), 128'h1);
        cyc(); req_off();
        chk("w_rd_misal_rvalid", 128'(o_rvalid), 128'h0);

        req(1'b1, 1'b1, 1'b1, 2'b11, 64'hA8, 1'b0, 64'h0123_4567_89AB_CDEF);
        chk("amo_d_misal", 128'(o_misaligned), 128'h0);
        cyc(); req_off();
        chk("rbw_rvalid", 128'(o_rvalid), 128'h1);
        chk("rbw_old_data", 128'(o_rdata), 128'h0);
        rd_chk("rd_amo_d", 2'b11, 64'hA8, 1'b0, 64'h0123_4567_89AB_CDEF);

        req(1'b0, 1'b1, 1'b0, 2'b00, 64'hA1, 1'b0, 64'h77);
        cyc(); req_off();
        rd_chk("rd_after_b_store", 2'b11, 64'hA0, 1'b0, 64'hDEAD_BEEF_0000_7700);

        // Line fill into set 3 way 1 with gaps between beats
        i_fill_start = 1'b1; i_addr = 64'h60; i_way_sel = 1'b1;
        cyc(); i_fill_start = 1'b0;
        chk("fill_busy", 128'(o_busy), 128'h1);
        chk("fill_ready", 128'(o_fill_ready), 128'h1);
        cyc();
        i_fill_valid = 1'b1; i_fill_data = BEAT0;
        cyc(); i_fill_valid = 1'b0; i_fill_data = '0;
        chk("fill_done_early", 128'(o_fill_done), 128'h0);
        req(1'b1, 1'b0, 1'b0, 2'b01, 64'h61, 1'b1, 64'h0);
        chk("fill_misal_masked", 128'(o_misaligned), 128'h0);
        cyc(); req_off();
        chk("fill_rd_ignored", 128'(o_rvalid), 128'h0);
        req(1'b0, 1'b1, 1'b0, 2'b11, 64'h60, 1'b1, 64'hBAD0_BAD0_BAD0_BAD0);
        cyc(); req_off();
        i_fill_valid = 1'b1; i_fill_data = BEAT1;
        cyc(); i_fill_valid = 1'b0; i_fill_data = '0;
        chk("fill_done_pulse", 128'(o_fill_done), 128'h1);
        chk("fill_busy_drop", 128'(o_busy), 128'h0);
        chk("fill_ready_drop", 128'(o_fill_ready), 128'h0);
        cyc();
        chk("fill_done_clear", 128'(o_fill_done), 128'h0);
        rd_chk("fill_rd_w0", 2'b11, 64'h60, 1'b1, 64'h1111_1111_1111_1101);
        rd_chk("fill_rd_w1", 2'b11, 64'h68, 1'b1, 64'h1111_1111_1111_1102);
        rd_chk("fill_rd_w2", 2'b11, 64'h70, 1'b1, 64'h2222_2222_2222_2203);
        rd_chk("fill_rd_w3", 2'b11, 64'h78, 1'b1, 64'h2222_2222_2222_2204);
        rd_chk("fill_rd_way0", 2'b11, 64'h60, 1'b0, 64'h0);

        // Evict that line with back-pressure on the first beat
        i_evict_start = 1'b1; i_addr = 64'h60; i_way_sel = 1'b1;
        cyc(); i_evict_start = 1'b0;
        chk("ev_entry_busy", 128'(o_busy), 128'h1);
        chk("ev_entry_valid", 128'(o_evict_valid), 128'h0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("ev_hold_valid", 128'(o_evict_valid), 128'h1);
            chk("ev_hold_data", o_evict_data, BEAT0);
            chk("ev_hold_last", 128'(o_evict_last), 128'h0);
        end
        i_evict_ready = 1'b1;
        cyc();
        chk("ev_b1_data", o_evict_data, BEAT1);
        chk("ev_b1_last", 128'(o_evict_last), 128'h1);
        cyc();
        i_evict_ready = 1'b0;
        chk("ev_end_valid", 128'(o_evict_valid), 128'h0);
        chk("ev_end_busy", 128'(o_busy), 128'h0);

        // Simultaneous starts: eviction wins
        i_evict_start = 1'b1; i_fill_start = 1'b1; i_addr = 64'hA0; i_way_sel = 1'b0;
        cyc(); i_evict_start = 1'b0; i_fill_start = 1'b0;
        chk("both_fill_ready", 128'(o_fill_ready), 128'h0);
        chk("both_busy", 128'(o_busy), 128'h1);
        cyc();
        chk("both_b0", o_evict_data, {64'h0123_4567_89AB_CDEF, 64'hDEAD_BEEF_0000_7700});
        i_evict_ready = 1'b1;
        cyc();
        chk("both_b1", o_evict_data, 128'h0);
        chk("both_b1_last", 128'(o_evict_last), 128'h1);
        cyc();
        i_evict_ready = 1'b0;
        chk("both_done_busy", 128'(o_busy), 128'h0);

        // Reset mid-fill after the first beat
        i_fill_start = 1'b1; i_addr = 64'hE0; i_way_sel = 1'b0;
        cyc(); i_fill_start = 1'b0;
        i_fill_valid = 1'b1; i_fill_data = BEAT0;
        cyc(); i_fill_valid = 1'b0;
        chk("midfill_busy", 128'(o_busy), 128'h1);
        i_rst_n = 1'b0;
        #2;
        chk("rst_midfill_busy", 128'(o_busy), 128'h0);
        chk("rst_midfill_ready", 128'(o_fill_ready), 128'h0);
        #2;
        i_rst_n = 1'b1;
        cyc();
        chk("post_rst_ready", 128'(o_fill_ready), 128'h0);
        rd_chk("post_rst_s7", 2'b11, 64'hE0, 1'b0, 64'h0);
        rd_chk("post_rst_s5", 2'b11, 64'hA0, 1'b0, 64'h0);
        rd_chk("post_rst_s3w1", 2'b11, 64'h60, 1'b1, 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
